// File: rtl/flipflop_jk_arbiter.sv
// Round-robin arbiter that shares one JK flop between two requesters,
// drives J/K for cnt+1 edges and returns the checked final flop value.
module flipflop_jk_arbiter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  input  logic [1:0]       i_req0_cmd,
  input  logic [CNT_W-1:0] i_req0_cnt,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [1:0]       i_req1_cmd,
  input  logic [CNT_W-1:0] i_req1_cnt,
  output logic             o_req1_ready,
  output logic             o_j,
  output logic             o_k,
  input  logic             i_q,
  output logic             o_resp_valid,
  output logic             o_resp_id,
  output logic             o_resp_q,
  output logic             o_resp_err,
  output logic             o_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic             rr;
  logic [CNT_W-1:0] cnt_r;
  logic             id_r;
  logic             q0;
  logic [1:0]       cmd_r;
  logic             flip_r;

  logic             gnt0;
  logic             gnt1;
  logic             handshake;
  logic [1:0]       cmd_sel;
  logic [CNT_W-1:0] cnt_sel;
  logic             exp_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (i_rst_n && state == ST_IDLE) begin
      if (i_req0_valid && (!i_req1_valid || !rr)) begin
        gnt0 = 1'b1;
      end else if (i_req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;
  assign handshake    = gnt0 | gnt1;
  assign cmd_sel      = gnt1 ? i_req1_cmd : i_req0_cmd;
  assign cnt_sel      = gnt1 ? i_req1_cnt : i_req0_cnt;
  assign o_busy       = (state != ST_IDLE);

  // cnt+1 toggles flip q exactly when cnt is even, so only ~cnt[0] is kept
  always_comb begin
    exp_q = q0;
    case (cmd_r)
      2'b00:   exp_q = q0;
      2'b01:   exp_q = 1'b0;
      2'b10:   exp_q = 1'b1;
      default: exp_q = q0 ^ flip_r;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      rr           <= 1'b0;
      cnt_r        <= '0;
      id_r         <= 1'b0;
      q0           <= 1'b0;
      cmd_r        <= 2'b00;
      flip_r       <= 1'b0;
      o_j          <= 1'b0;
      o_k          <= 1'b0;
      o_resp_valid <= 1'b0;
      o_resp_id    <= 1'b0;
      o_resp_q     <= 1'b0;
      o_resp_err   <= 1'b0;
    end else begin
      o_resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            o_j    <= cmd_sel[1];
            o_k    <= cmd_sel[0];
            cmd_r  <= cmd_sel;
            cnt_r  <= cnt_sel;
            flip_r <= ~cnt_sel[0];
            id_r   <= gnt1;
            q0     <= i_q;
            rr     <= ~gnt1;
            state  <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (cnt_r == '0) begin
            o_j   <= 1'b0;
            o_k   <= 1'b0;
            state <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_RESP: begin
          o_resp_valid <= 1'b1;
          o_resp_id    <= id_r;
          o_resp_q     <= i_q;
          o_resp_err   <= (i_q != exp_q);
          state        <= ST_IDLE;
        end
        default: begin
          o_j   <= 1'b0;
          o_k   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
